// File: rtl/approx_mult_pkg.sv
// ============================================================================
// Module  : approx_mult_pkg
// Brief   : Shared mode encodings, defaults and helpers for approx_mult_pipe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package approx_mult_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_KMAX  = 8;

   typedef enum logic [1:0] {
      MODE_ADAPT = 2'b00,
      MODE_FIXED = 2'b01,
      MODE_EXACT = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_e;

   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lod_segment.sv
// ============================================================================
// Module  : lod_segment
// Brief   : Leading-one detect and K-bit segment extraction for one operand.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lod_segment
   import approx_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int KMAX  = DEF_KMAX
) (
   input  logic [WIDTH-1:0]              operand_i,
   input  logic [clog2(WIDTH+1)-1:0]     k_i,
   output logic [WIDTH-1:0]              seg_o,
   output logic [clog2(WIDTH+1)-1:0]     sh_o,
   output logic                          trunc_o
);

   localparam int KW = clog2(WIDTH + 1);

   logic [WIDTH-1:0] smear;
   logic [KW-1:0]    cnt;
   logic [KW-1:0]    sh;

   // Smearing ones below the leading one turns the priority encode into a
   // population count: cnt = p + 1 for a nonzero operand, 0 otherwise.
   always_comb begin
      smear = operand_i;
      for (int i = 1; i < WIDTH; i = i * 2) begin
         smear = smear | (smear >> i);
      end
      cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + KW'(smear[i]);
      end
      sh = (cnt > k_i) ? (cnt - k_i) : '0;
   end

   assign seg_o   = operand_i >> sh;
   assign sh_o    = sh;
   assign trunc_o = |(operand_i & ~({WIDTH{1'b1}} << sh));

endmodule

`default_nettype wire

// File: rtl/approx_mult_pipe.sv
// ============================================================================
// Module  : approx_mult_pipe
// Brief   : 3-stage leading-one-truncation approximate multiplier, valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module approx_mult_pipe
   import approx_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int KMAX  = DEF_KMAX
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic [1:0]           in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_y,
   output logic                 out_exact
);

   localparam int KW = clog2(WIDTH + 1);
   localparam int PW = 2 * WIDTH;

   logic              en;
   logic [KW-1:0]     k_d;
   logic [WIDTH-1:0]  sega_d, segb_d;
   logic [KW-1:0]     sha_d, shb_d;
   logic              trunca_d, truncb_d;

   logic              s1_valid_q;
   logic [WIDTH-1:0]  s1_sega_q, s1_segb_q;
   logic [KW-1:0]     s1_sha_q, s1_shb_q;
   logic              s1_trunc_q;

   logic              s2_valid_q;
   logic [PW-1:0]     s2_prod_q;
   logic [KW:0]       s2_shtot_q;
   logic              s2_exact_q;

   logic              out_valid_q;
   logic [PW-1:0]     out_y_q;
   logic              out_exact_q;

   logic [PW-1:0]     prod_d;
   logic [KW:0]       shtot_d;
   logic              exact_d;

   assign en       = !out_valid_q || out_ready;
   assign in_ready = en;

   // Exact mode uses K = WIDTH, which makes the segment the whole operand.
   always_comb begin
      k_d = KW'(WIDTH);
      case (mode_e'(in_mode))
         MODE_ADAPT: begin
            if ((|in_a[WIDTH-1 -: 4]) || (|in_b[WIDTH-1 -: 4]))
               k_d = KW'(KMAX);
            else if ((|in_a[WIDTH-5 -: 4]) || (|in_b[WIDTH-5 -: 4]))
               k_d = KW'(KMAX - 1);
            else
               k_d = KW'(KMAX - 2);
         end
         MODE_FIXED: k_d = KW'(KMAX);
         default:    k_d = KW'(WIDTH);
      endcase
   end

   lod_segment #(.WIDTH(WIDTH), .KMAX(KMAX)) u_lod_a (
      .operand_i (in_a),
      .k_i       (k_d),
      .seg_o     (sega_d),
      .sh_o      (sha_d),
      .trunc_o   (trunca_d)
   );

   lod_segment #(.WIDTH(WIDTH), .KMAX(KMAX)) u_lod_b (
      .operand_i (in_b),
      .k_i       (k_d),
      .seg_o     (segb_d),
      .sh_o      (shb_d),
      .trunc_o   (truncb_d)
   );

   // A zero segment means a zero operand, so the product is exactly zero
   // regardless of truncation on the other side.
   assign prod_d  = {{WIDTH{1'b0}}, s1_sega_q} * {{WIDTH{1'b0}}, s1_segb_q};
   assign shtot_d = {1'b0, s1_sha_q} + {1'b0, s1_shb_q};
   assign exact_d = !s1_trunc_q || (s1_sega_q == '0) || (s1_segb_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_sega_q   <= '0;
         s1_segb_q   <= '0;
         s1_sha_q    <= '0;
         s1_shb_q    <= '0;
         s1_trunc_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_prod_q   <= '0;
         s2_shtot_q  <= '0;
         s2_exact_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_exact_q <= 1'b0;
      end else if (en) begin
         s1_valid_q  <= in_valid;
         s2_valid_q  <= s1_valid_q;
         out_valid_q <= s2_valid_q;
         if (in_valid) begin
            s1_sega_q  <= sega_d;
            s1_segb_q  <= segb_d;
            s1_sha_q   <= sha_d;
            s1_shb_q   <= shb_d;
            s1_trunc_q <= trunca_d || truncb_d;
         end
         if (s1_valid_q) begin
            s2_prod_q  <= prod_d;
            s2_shtot_q <= shtot_d;
            s2_exact_q <= exact_d;
         end
         if (s2_valid_q) begin
            out_y_q     <= s2_prod_q << s2_shtot_q;
            out_exact_q <= s2_exact_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_exact = out_exact_q;

endmodule

`default_nettype wire

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
- Parametrised, 3-stage pipelined successor to the combinational leading-one-truncation approximate multiplier.
- Each operand is reduced to a K-bit segment starting at its leading one. The segments are multiplied, and the product is shifted back into place.
- K is per-transaction selectable: adaptive, fixed, or exact bypass. The block also reports whether the result is exact.
- Sits between operand producers and accumulators in the low-power datapath, using a valid/ready handshake.

Parameters:
- WIDTH, 32: operand width. Must be ≥ 8 and a multiple of 4.
- KMAX, 8: maximum segment width. Must satisfy 3 ≤ KMAX ≤ WIDTH.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  WIDTH  operand A, unsigned
- in_b  in  WIDTH  operand B, unsigned
- in_mode  in  2  00 adaptive, 01 fixed KMAX, 10 exact, 11 reserved (treated as exact)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_y  out  2*WIDTH  product, unsigned
- out_exact  out  1  1 when out_y equals the true product in_a*in_b

Behaviour:
- Reset
  - Async assert clears all stage-valid bits and all data registers.
  - out_valid=0, out_y=0, out_exact=0. in_ready=1 after reset.
  - Reset mid-operation discards all in-flight beats; nothing is emitted afterwards.
- Pipeline advance
  - en = !out_valid || out_ready.
  - in_ready = en.
  - Beat accepted when in_valid && in_ready.
  - All stages advance together when en=1 and bubbles propagate. When en=0 every stage holds, and out_y/out_exact/out_valid stay stable.
- Latency and throughput
  - An accepted beat appears on out_* 3 cycles after acceptance, with no stalls.
  - Throughput is 1 beat per cycle. Order is preserved.
- Stage 1: leading-one detect, K select, segment extract.
  - p = index of highest set bit of the operand; p = 0 for a zero operand.
  - Adaptive K:
    - If any of bits [WIDTH-1:WIDTH-4] of A or B is set, K = KMAX.
    - Else if any of bits [WIDTH-5:WIDTH-8] of A or B is set, K = KMAX-1.
    - Else K = KMAX-2.
  - Fixed mode: K = KMAX.
  - Per operand, if p < K: seg = operand[K-1:0] and sh = 0.
  - Otherwise: seg = operand[p:p-K+1] and sh = p-K+1.
  - trunc = 1 if any discarded bit below the segment is nonzero.
  - Exact mode: seg = full operand, sh = 0, trunc = 0.
- Stage 2: multiply.
  - prod = segA*segB. The multiplier is sized WIDTH x WIDTH to cover exact mode.
  - shtot = shA + shB, range 0..2*(WIDTH-3).
  - Carry exact = !(truncA || truncB).
- Stage 3: shift and register.
  - out_y = prod << shtot, truncated to 2*WIDTH bits. The result never overflows.
  - out_exact = carried flag. A zero operand always yields out_y=0 and out_exact=1.
- in_mode and operands are captured together at acceptance. A mode change between beats affects only the new beat.
- Simultaneous out_ready and new input while full: the output beat leaves and the new beat enters in the same cycle.

Decomposition:
- Shared package (approx_mult_pkg):
  - mode encodings: MODE_ADAPT, MODE_FIXED, MODE_EXACT
  - function clog2
  - default KMAX and WIDTH localparams
- Sub-module: lod_segment (WIDTH, KMAX), instantiated twice in stage 1.
  - Inputs: operand and K.
  - Outputs: seg, sh, trunc.
  - Implemented as a priority encoder plus barrel right-shift, with no per-bit if chains.

Test Plan (WIDTH=32, KMAX=8):
- Fixed: a=0x000000FF, b=0x00000003 -> out_y=0x2FD, out_exact=1, out_valid exactly 3 cycles after accept.
- Fixed: a=0xFFFFFFFF, b=0x00000001 -> segA=0xFF, sh=24, out_y=0x00000000FF000000, out_exact=0.
- Adaptive: a=0x01000000, b=0x00000005 -> K=7, segA=0x40, shA=18, out_y=0x0000000005000000, out_exact=1.
- Exact: a=b=0xFFFFFFFF -> out_y=0xFFFFFFFE00000001, out_exact=1. Also a=0 with any b in any mode -> out_y=0, out_exact=1.
- Backpressure: stream 4 beats, hold out_ready=0 after the first result -> in_ready=0, out_y stable. Release -> all 4 results in order, no loss or duplication.
- Reset: assert rst with 2 beats in flight -> out_valid=0 immediately (async). After release, no stale results; the next beat has normal 3-cycle latency.
